// File: rtl/br_pkg.sv
// ---------------------------------------------------------------------------
// br_pkg -- shared definitions for the register-file dump block and the
// register file it reads.
//   DATA_W    : register width
//   ADDR_W    : register index width
//   REG_COUNT : number of architectural registers
//   br_state_t: dump sequencer states
// ---------------------------------------------------------------------------
package br_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int REG_COUNT = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        SEND = 3'd2,
        CSUM = 3'd3,
        FIN  = 3'd4
    } br_state_t;

endpackage

// File: rtl/br_dump_csum.sv
// ---------------------------------------------------------------------------
// br_dump_csum -- XOR accumulator over every word accepted by the sink.
// Only instantiated when BR_DUMP_CHECKSUM_EN is defined.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset (clears accumulator)
//   clr  in  clear accumulator (start of a new dump)
//   en   in  fold din into the accumulator
//   din  in  accepted data word
//   acc  out running XOR of accepted words
// ---------------------------------------------------------------------------
module br_dump_csum
    import br_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] acc
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule

// File: rtl/br_dump.sv
// ---------------------------------------------------------------------------
// br_dump -- streams register-file entries FIRST_REG..LAST_REG out over a
// valid/ready interface, one word per two cycles at best.
// Optional feature macro: BR_DUMP_CHECKSUM_EN -- appends an XOR checksum
// word (tx_idx = 31) after the last register.
// Parameters:
//   FIRST_REG  first register index streamed
//   LAST_REG   last register index streamed (FIRST_REG <= LAST_REG <= 31)
// Ports:
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   start     in  request a dump (sampled only when idle)
//   abort     in  cancel a dump in progress
//   RA        out register-file read index
//   DR        in  combinational read data for RA
//   tx_data   out streamed word
//   tx_idx    out register index of tx_data
//   tx_valid  out tx_data/tx_idx valid
//   tx_ready  in  sink accepts the word
//   busy      out dump in progress (any state but IDLE)
//   done      out one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module br_dump
    import br_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] RA,
    input  logic [DATA_W-1:0] DR,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W-1:0] tx_idx,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(FIRST_REG);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(LAST_REG);

    br_state_t         state;
    logic [ADDR_W-1:0] cnt;
    logic              last;

    assign last = (cnt == LAST_IDX);

`ifdef BR_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              csum_clr;
    logic              csum_en;

    // Accumulate on the same edge the sink takes the word; abort wins.
    assign csum_clr = (state == IDLE) && start && !abort;
    assign csum_en  = (state == SEND) && tx_ready && !abort;

    br_dump_csum u_csum (
        .clk (clk),
        .rst (rst),
        .clr (csum_clr),
        .en  (csum_en),
        .din (tx_data),
        .acc (csum)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            RA       <= '0;
            tx_data  <= '0;
            tx_idx   <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort && (state != IDLE)) begin
                // Abort beats any handshake in the same cycle.
                state    <= IDLE;
                RA       <= '0;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            cnt   <= FIRST_IDX;
                            RA    <= FIRST_IDX;
                            busy  <= 1'b1;
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        tx_data  <= DR;
                        tx_idx   <= cnt;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                    SEND: begin
                        if (tx_ready) begin
                            if (!last) begin
                                // Counter only advances below LAST_IDX, so it
                                // cannot wrap.
                                cnt      <= cnt + 1'b1;
                                RA       <= cnt + 1'b1;
                                tx_valid <= 1'b0;
                                state    <= ADDR;
                            end else begin
`ifdef BR_DUMP_CHECKSUM_EN
                                // The accumulator only sees the final word on
                                // this edge, so fold it in here; tx_valid stays
                                // high straight into the checksum word.
                                tx_data <= csum ^ tx_data;
                                tx_idx  <= ADDR_W'(REG_COUNT - 1);
                                state   <= CSUM;
`else
                                tx_valid <= 1'b0;
                                RA       <= '0;
                                done     <= 1'b1;
                                state    <= FIN;
`endif
                            end
                        end
                    end
`ifdef BR_DUMP_CHECKSUM_EN
                    CSUM: begin
                        if (tx_ready) begin
                            tx_valid <= 1'b0;
                            RA       <= '0;
                            done     <= 1'b1;
                            state    <= FIN;
                        end
                    end
`endif
                    FIN: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        state    <= IDLE;
                        RA       <= '0;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_br_dump.sv
// ---------------------------------------------------------------------------
// tb_br_dump -- directed bench for br_dump. A default instance streams the
// full register file; a second instance is built with FIRST_REG=LAST_REG=7.
// The checksum word is expected only when BR_DUMP_CHECKSUM_EN is defined.
// ---------------------------------------------------------------------------
module tb_br_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort, tx_ready;
    logic [4:0]  RA, tx_idx;
    logic [31:0] DR, tx_data;
    logic        tx_valid, busy, done;

    logic        start7, abort7, ready7;
    logic [4:0]  RA7, tx_idx7;
    logic [31:0] DR7, tx_data7;
    logic        tx_valid7, busy7, done7;

    logic [31:0] br [32];

    int n_checks = 0;
    int n_pass   = 0;

`ifdef BR_DUMP_CHECKSUM_EN
    localparam int NW = 33;
`else
    localparam int NW = 32;
`endif

    always #5 clk = ~clk;

    assign DR  = br[RA];
    assign DR7 = br[RA7];

    br_dump dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .RA       (RA),
        .DR       (DR),
        .tx_data  (tx_data),
        .tx_idx   (tx_idx),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    br_dump #(.FIRST_REG(7), .LAST_REG(7)) dut7 (
        .clk      (clk),
        .rst      (rst),
        .start    (start7),
        .abort    (abort7),
        .RA       (RA7),
        .DR       (DR7),
        .tx_data  (tx_data7),
        .tx_idx   (tx_idx7),
        .tx_valid (tx_valid7),
        .tx_ready (ready7),
        .busy     (busy7),
        .done     (done7)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // With tx_ready high, advance until the given index is on offer.
    task automatic run_to(input logic [4:0] target);
        int cyc;
        cyc = 0;
        while (!(tx_valid && tx_idx == target) && cyc < 100) begin
            tick();
            cyc++;
        end
        check("reach_idx", 32'(tx_idx), 32'(target));
    endtask

    task automatic full_dump(input string tag);
        int          e, cyc;
        logic [31:0] acc, exp_d;
        logic [4:0]  exp_i;
        e = 0; cyc = 0; acc = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_addr_busy"}, 32'(busy), 32'd1);
        check({tag, "_addr_valid"}, 32'(tx_valid), 32'd0);
        tick();
        check({tag, "_latency_valid"}, 32'(tx_valid), 32'd1);
        while (e < NW && cyc < 400) begin
            if (tx_valid) begin
                if (e < 32) begin
                    exp_d = br[e];
                    exp_i = 5'(e);
                end else begin
                    exp_d = acc;
                    exp_i = 5'd31;
                end
                check({tag, "_data"}, tx_data, exp_d);
                check({tag, "_idx"}, 32'(tx_idx), 32'(exp_i));
                if (e < 32) acc = acc ^ br[e];
                e++;
            end
            tick();
            cyc++;
        end
        check({tag, "_word_count"}, 32'(e), 32'(NW));
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_valid_after"}, 32'(tx_valid), 32'd0);
        tick();
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ra"}, 32'(RA), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) br[i] = 32'(i) * 32'h1111_1111;
        rst = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b1;
        start7 = 1'b0; abort7 = 1'b0; ready7 = 1'b1;

        // Reset state
        tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ra", 32'(RA), 32'd0);
        check("rst_data", tx_data, 32'd0);
        check("rst_idx", 32'(tx_idx), 32'd0);
        rst = 1'b0;
        tick();

        // Full dump with ready always high
        full_dump("full");

        // Back-pressure on word 3; a start while busy must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to(5'd3);
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            tick();
            check("hold_valid", 32'(tx_valid), 32'd1);
            check("hold_idx", 32'(tx_idx), 32'd3);
            check("hold_data", tx_data, 32'h3333_3333);
        end
        start = 1'b0;
        tx_ready = 1'b1;
        tick();
        check("hold_release_valid", 32'(tx_valid), 32'd0);
        tick();
        check("resume_idx", 32'(tx_idx), 32'd4);
        check("resume_data", tx_data, 32'h4444_4444);

        // Abort while idx 10 is on offer (with ready high: abort wins)
        run_to(5'd10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(tx_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ra", 32'(RA), 32'd0);
        tick();
        check("abort_no_done", 32'(done), 32'd0);

        // start and abort together in IDLE stay idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_busy", 32'(busy), 32'd0);
        tick();
        check("start_abort_valid", 32'(tx_valid), 32'd0);

        // Restart from idx 0, then asynchronous reset mid-dump
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("restart_valid", 32'(tx_valid), 32'd1);
        check("restart_idx", 32'(tx_idx), 32'd0);
        run_to(5'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(tx_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_data", tx_data, 32'd0);
        check("arst_idx", 32'(tx_idx), 32'd0);
        check("arst_ra", 32'(RA), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        full_dump("after_rst");

        // Single-register instance
        start7 = 1'b1;
        tick();
        start7 = 1'b0;
        check("one_ra", 32'(RA7), 32'd7);
        tick();
        check("one_valid", 32'(tx_valid7), 32'd1);
        check("one_idx", 32'(tx_idx7), 32'd7);
        check("one_data", tx_data7, 32'h7777_7777);
        tick();
`ifdef BR_DUMP_CHECKSUM_EN
        check("one_csum_valid", 32'(tx_valid7), 32'd1);
        check("one_csum_idx", 32'(tx_idx7), 32'd31);
        check("one_csum_data", tx_data7, 32'h7777_7777);
        tick();
`endif
        check("one_done", 32'(done7), 32'd1);
        check("one_valid_after", 32'(tx_valid7), 32'd0);
        tick();
        check("one_done_low", 32'(done7), 32'd0);
        check("one_busy", 32'(busy7), 32'd0);

`ifdef BR_DUMP_CHECKSUM_EN
        // All-ones file: an even number of identical words XORs to zero
        for (int i = 0; i < 32; i++) br[i] = 32'hFFFF_FFFF;
        full_dump("ones");
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/br_dump.md
BR_DUMP -- requirements
Module: br_dump

Interface
REQ-001 The block SHALL have parameter FIRST_REG, default 0, meaning the first register index streamed.
REQ-002 The block SHALL have parameter LAST_REG, default 31, meaning the last register index streamed; FIRST_REG <= LAST_REG <= 31.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a dump; sampled only in IDLE.
REQ-006 The block SHALL have port abort, input, 1 bit: cancel a dump in progress.
REQ-007 The block SHALL have port RA, output, 5 bits: index driven to the register-file read port.
REQ-008 The block SHALL have port DR, input, 32 bits: combinational read data returned for RA.
REQ-009 The block SHALL have port tx_data, output, 32 bits: streamed word.
REQ-010 The block SHALL have port tx_idx, output, 5 bits: register index of tx_data.
REQ-011 The block SHALL have port tx_valid, output, 1 bit: tx_data and tx_idx are valid.
REQ-012 The block SHALL have port tx_ready, input, 1 bit: the sink accepts the word.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 The block SHALL have port done, output, 1 bit: one-cycle pulse after the final word is accepted.

Function
REQ-015 The FSM SHALL have the states IDLE, ADDR, SEND, CSUM and FIN.
REQ-016 In IDLE with start=1, the FSM SHALL load the index counter with FIRST_REG and move to ADDR.
REQ-017 In ADDR, RA SHALL equal the counter; on the next edge DR SHALL be captured into tx_data, the counter into tx_idx, and the FSM SHALL move to SEND.
REQ-018 In SEND, tx_valid SHALL be 1, and tx_data and tx_idx SHALL hold stable until a cycle with tx_valid and tx_ready both high.
REQ-019 On a handshake with counter < LAST_REG, the counter SHALL increment by 1 and the FSM SHALL move to ADDR.
REQ-020 On a handshake with counter == LAST_REG, the FSM SHALL move to CSUM when BR_DUMP_CHECKSUM_EN is defined, otherwise to FIN.
REQ-021 FIN SHALL assert done for exactly one cycle and then return to IDLE.
REQ-022 Latency: start in cycle N SHALL produce the first tx_valid in cycle N+2.
REQ-023 Throughput SHALL be at most one word per two cycles.
REQ-024 tx_valid SHALL NOT fall without a handshake, except on abort or rst.
REQ-025 abort=1 in any non-IDLE state SHALL return the FSM to IDLE on the next edge, with tx_valid=0 and no done pulse.
REQ-026 abort SHALL take priority over a simultaneous handshake.
REQ-027 start while busy=1 SHALL be ignored; start and abort together in IDLE SHALL leave the FSM in IDLE.
REQ-028 The counter SHALL never exceed LAST_REG and SHALL never wrap.
REQ-029 When FIRST_REG == LAST_REG, the block SHALL stream exactly one word.
REQ-030 In IDLE, RA SHALL be 0.

Reset
REQ-031 rst=1 SHALL asynchronously force: state IDLE, counter 0, RA 0, tx_data 0, tx_idx 0, tx_valid 0, busy 0, done 0, and checksum accumulator 0.
REQ-032 rst asserted mid-dump SHALL discard the dump with no done pulse; the first start after release SHALL begin again at FIRST_REG.

Configuration
REQ-033 With macro BR_DUMP_CHECKSUM_EN defined, the accumulator SHALL clear on start and XOR in every accepted data word.
REQ-034 With BR_DUMP_CHECKSUM_EN defined, CSUM SHALL present the accumulator on tx_data with tx_idx=31 and tx_valid=1, obeying the same handshake, then move to FIN.
REQ-035 With BR_DUMP_CHECKSUM_EN undefined, the CSUM state and the accumulator SHALL be absent, and the stream length SHALL be LAST_REG-FIRST_REG+1 words.

Structure
REQ-036 Package br_pkg SHALL hold the state enum, DATA_W=32, ADDR_W=5 and REG_COUNT=32, shared with the register file.
REQ-037 The checksum accumulator SHALL be sub-module br_dump_csum, instantiated only under BR_DUMP_CHECKSUM_EN; everything else SHALL be flat.

Verification
REQ-038 Register file preloaded with BR[i]=i*0x11111111, tx_ready=1, start pulse -> 32 words with tx_idx 0..31 and correct data, first tx_valid 2 cycles after start, done pulse after word 31.
REQ-039 tx_ready held low 5 cycles on word 3 -> tx_data and tx_idx stable all 5 cycles, then the stream continues at idx 4.
REQ-040 abort during SEND of idx 10 -> tx_valid=0 and busy=0 next cycle, no done pulse; a new start restarts at idx 0.
REQ-041 rst pulse mid-dump between clock edges -> outputs zero immediately, not waiting for a clock edge.
REQ-042 FIRST_REG=LAST_REG=7 -> exactly one word with idx 7, then done.
REQ-043 BR_DUMP_CHECKSUM_EN defined with all registers 0xFFFFFFFF -> 33rd word 0x00000000 with idx 31, then done.
